// File: rtl/score_pkg.sv
// Shared types and constants for the score keeper: FSM states, BCD width and
// active-low seven-segment decode table.
package score_pkg;

  localparam int unsigned BCD_W = 4;

  typedef enum logic [1:0] {StIdle, StRun, StCommit} state_e;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Packed so entry 0 is the rightmost element: {g,f,e,d,c,b,a}, active low.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'b0011000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
    return (d <= 4'd9) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/score_keeper_7seg_if.sv
// Control pulses, score buses and display drive of the score keeper.
interface score_keeper_7seg_if #(
  parameter int unsigned DIGITS = 4
);
  logic                game_start;
  logic                score_inc;
  logic                game_over;
  logic                show_high;
  logic [4*DIGITS-1:0] score_bcd;
  logic [4*DIGITS-1:0] high_bcd;
  logic                running;
  logic                saturated;
  logic                new_high;
  logic [DIGITS-1:0]   an;
  logic [6:0]          seg;

  modport master (
    output game_start, score_inc, game_over, show_high,
    input  score_bcd, high_bcd, running, saturated, new_high, an, seg
  );

  modport slave (
    input  game_start, score_inc, game_over, show_high,
    output score_bcd, high_bcd, running, saturated, new_high, an, seg
  );
endinterface

// File: rtl/seg7_scan.sv
// Time-multiplexed seven-segment scan: slot counter, digit index, leading-zero
// blanking and registered active-low an/seg drive.
module seg7_scan
  import score_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [BCD_W*DIGITS-1:0] score_bcd,
  input  logic [BCD_W*DIGITS-1:0] high_bcd,
  input  logic                    show_high,
  output logic [DIGITS-1:0]       an,
  output logic [6:0]              seg
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CntW-1:0]           cnt_q;
  logic [IdxW-1:0]           idx_q, idx_next;
  logic [DIGITS-1:0]         an_q, an_next;
  logic [6:0]                seg_q, seg_next;
  logic                      tc;
  logic                      blank;
  logic [BCD_W*DIGITS-1:0]   src, upper;
  logic [BCD_W-1:0]          digit;

  always_comb begin
    tc       = (cnt_q == CntW'(SCAN_DIV - 1));
    src      = show_high ? high_bcd : score_bcd;
    digit    = src[BCD_W*idx_q +: BCD_W];
    // Nothing non-zero at or above this digit means it is a leading zero.
    upper    = src >> (BCD_W * idx_q);
    blank    = LZ_BLANK && (idx_q != '0) && (upper == '0);
    seg_next = blank ? SEG_BLANK : seg_decode(digit);
    an_next  = ~(DIGITS'(1) << idx_q);
    idx_next = (idx_q == IdxW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end

  // The slot just finished selects what is shown next, so an and seg move together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_q  <= '1;
      seg_q <= SEG_BLANK;
    end else begin
      cnt_q <= tc ? '0 : cnt_q + 1'b1;
      if (tc) begin
        idx_q <= idx_next;
        an_q  <= an_next;
        seg_q <= seg_next;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: rtl/score_keeper_7seg.sv
// Game score unit: BCD run score with saturation, persistent high score with
// new-record flag, and a multiplexed seven-segment display.
module score_keeper_7seg
  import score_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000,
  parameter bit          LZ_BLANK = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  score_keeper_7seg_if.slave  bus
);

  localparam int unsigned W = BCD_W * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_e         state_q;
  logic [W-1:0]   score_q, high_q, score_plus;
  logic           running_q, sat_q, new_high_q;
  logic           carry;
  logic [DIGITS-1:0] an_w;
  logic [6:0]     seg_w;

  // BCD ripple increment; wraps at all nines, which the FSM never lets through.
  always_comb begin
    carry      = 1'b1;
    score_plus = score_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (score_q[BCD_W*i +: BCD_W] == 4'd9) begin
          score_plus[BCD_W*i +: BCD_W] = '0;
        end else begin
          score_plus[BCD_W*i +: BCD_W] = score_q[BCD_W*i +: BCD_W] + 4'd1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      score_q    <= '0;
      high_q     <= '0;
      running_q  <= 1'b0;
      sat_q      <= 1'b0;
      new_high_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.game_start) begin
            score_q    <= '0;
            sat_q      <= 1'b0;
            new_high_q <= 1'b0;
            running_q  <= 1'b1;
            state_q    <= StRun;
          end
        end
        StRun: begin
          if (bus.score_inc) begin
            if (score_q != ALL_NINES) score_q <= score_plus;
            sat_q <= (score_q == ALL_NINES) || (score_plus == ALL_NINES);
          end
          if (bus.game_over) begin
            running_q <= 1'b0;
            state_q   <= StCommit;
          end
        end
        StCommit: begin
          // Valid BCD orders the same as plain unsigned binary.
          if (score_q > high_q) begin
            high_q     <= score_q;
            new_high_q <= 1'b1;
          end
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  seg7_scan #(
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV),
    .LZ_BLANK (LZ_BLANK)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .score_bcd (score_q),
    .high_bcd  (high_q),
    .show_high (bus.show_high),
    .an        (an_w),
    .seg       (seg_w)
  );

  assign bus.score_bcd = score_q;
  assign bus.high_bcd  = high_q;
  assign bus.running   = running_q;
  assign bus.saturated = sat_q;
  assign bus.new_high  = new_high_q;
  assign bus.an        = an_w;
  assign bus.seg       = seg_w;

endmodule

// File: doc/score_keeper_7seg.md
Name: score_keeper_7seg

Overview:
- Parametrised game score unit: N-digit BCD run score, persistent high score and time-multiplexed active-low 7-segment drive.
- Sits between the game control logic and the board's seven-segment display.
- Generalises the fixed 4-digit score/high-score path to DIGITS digits, adds saturation, a full-width magnitude compare, leading-zero blanking and a new-record flag.

Parameters:
- DIGITS, 4, number of BCD digits in score, high score and display (1..8).
- SCAN_DIV, 50000, clk cycles per digit scan slot (>=2).
- LZ_BLANK, 1, 1 = blank leading zeros (digit 0 always shown); 0 = show all digits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- game_start  in  1  single-cycle pulse: start a new run.
- score_inc  in  1  single-cycle pulse: add 1 to run score.
- game_over  in  1  single-cycle pulse: end run, commit high score.
- show_high  in  1  level: 1 = display high score, 0 = display run score.
- score_bcd  out  4*DIGITS  run score, digit 0 in [3:0].
- high_bcd  out  4*DIGITS  high score.
- running  out  1  high while in RUN.
- saturated  out  1  run score has reached all nines.
- new_high  out  1  last commit raised the high score; cleared on game_start.
- an  out  DIGITS  digit enables, active low, one-hot-low; an[0] = least significant digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active low.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port is clk, reset port is rst_n.
- Reset values:
  - state IDLE; score_bcd 0, high_bcd 0; running, saturated, new_high 0.
  - an all ones, seg 7'b1111111.
  - scan counter 0, scan index 0.
- FSM states: IDLE, RUN, COMMIT.
  - IDLE: game_start -> clear score_bcd, saturated and new_high; go to RUN next cycle. score_inc and game_over are ignored.
  - RUN: score_inc increments score_bcd by 1 (BCD ripple carry, each digit 9->0 carries up), with a registered result the next cycle. game_over -> COMMIT. game_start is ignored.
  - COMMIT (one cycle): if score_bcd > high_bcd (full DIGITS-wide unsigned BCD compare, most significant digit first), then high_bcd <= score_bcd and new_high <= 1. Go to IDLE. All inputs are ignored.
- Saturation: at all-nines, score_inc leaves the score unchanged and sets saturated; the score never wraps to 0.
- Simultaneous score_inc and game_over in RUN: the increment is applied in the same cycle, and COMMIT compares the incremented value.
- Equal score and high score: no update; new_high stays 0.
- Score holds its value through IDLE, so the last run stays visible until the next game_start.
- Scan:
  - Free-running counter 0..SCAN_DIV-1, running in every state.
  - At the terminal count, the index advances (DIGITS-1 wraps to 0).
  - an and seg are registered and update together on the cycle after the terminal count.
  - Only one an bit is low at a time; there is never an all-low glitch.
- Digit source: high_bcd if show_high else score_bcd, sampled when the index advances. show_high changes take effect at the next slot.
- Blanking: with LZ_BLANK=1, any digit above the most significant non-zero digit gives seg 7'b1111111; digit 0 is always shown, so a value of 0 displays "0".
- Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0011000; any other code gives 1111111.
- Reset mid-run: everything returns to its reset values immediately, including high_bcd; the high score is not retained across rst_n.

Decomposition:
- Shared package score_pkg:
  - state enum (IDLE/RUN/COMMIT).
  - SEG_BLANK constant.
  - 10-entry segment decode constant table.
  - BCD digit width constant (4).
- One sub-module, seg7_scan: scan counter, index, blanking, decode and registered an/seg. It takes two packed BCD buses and show_high.
- Score FSM and BCD arithmetic stay in the top module.

Test Plan:
- Reset, then game_start, 1234 score_inc pulses, game_over -> score_bcd 16'h1234, high_bcd 16'h1234 two cycles after game_over, new_high 1, running 0.
- Second run with 0999 increments, then game_over -> high_bcd stays 16'h1234, new_high 0; a run reaching 1300 -> high_bcd 16'h1300 (hundreds-digit compare with thousands equal).
- DIGITS=2: game_start then 105 score_inc -> score_bcd 8'h99, saturated 1 from the 99th pulse onward, no wrap; score_inc and game_over in the same cycle at 98 -> committed high is 99.
- SCAN_DIV=4, score 0007, LZ_BLANK=1, show_high 0 -> an cycles 1110,1101,1011,0111 every 4 clk. seg is 1111000 on an[0] and 1111111 on the other three; score 0 shows 1000000 on an[0] only.
- Toggle show_high mid-slot with high score 1300 -> the current slot is unchanged; the next slot shows the high-score digit. Pulses of score_inc/game_over in IDLE and game_start in RUN cause no state change.
- Assert rst_n low mid-RUN for an arbitrary 3 ns -> all outputs return to their reset values with no clk edge needed; high_bcd is 0 after release.
